// File: rtl/jpeg_idct_pkg.sv
// Shared constants, FSM state type and element placement helper for the IDCT transpose stage.
package jpeg_idct_pkg;

    localparam int unsigned BLOCK_SAMPLES = 64;
    localparam int unsigned RAM_WORDS     = 32;
    localparam int unsigned SAMPLE_W      = 16;
    localparam int unsigned WORD_W        = 2 * SAMPLE_W;
    localparam int unsigned ADDR_W        = 5;

    typedef enum logic {
        ST_FILL,
        ST_DRAIN
    } xpose_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              half;
    } elem_loc_t;

    // Element (r,c) sits in word r*4 + c/2; odd columns occupy the upper half.
    function automatic elem_loc_t elem_loc(input logic [2:0] row, input logic [2:0] col);
        elem_loc_t loc;
        loc.addr = {row, col[2:1]};
        loc.half = col[0];
        return loc;
    endfunction

endpackage

// File: rtl/jpeg_idct_transpose_ram.sv
// 32x32 dual-port RAM with registered read data on each port; contents are never reset.
module jpeg_idct_transpose_ram
    import jpeg_idct_pkg::*;
(
    input  logic              clk0_i,
    input  logic              rst0_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [WORD_W-1:0] data0_i,
    input  logic              wr0_i,
    input  logic              clk1_i,
    input  logic              rst1_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [WORD_W-1:0] data1_i,
    input  logic              wr1_i,
    output logic [WORD_W-1:0] data0_o,
    output logic [WORD_W-1:0] data1_o
);

    logic [WORD_W-1:0] mem [RAM_WORDS];

    // Both write ports commit on clk0 so the array has a single driver; the
    // stage ties both clocks together.
    always_ff @(posedge clk0_i) begin
        if (wr0_i) begin
            mem[addr0_i] <= data0_i;
        end
        if (wr1_i) begin
            mem[addr1_i] <= data1_i;
        end
    end

    always_ff @(posedge clk0_i or posedge rst0_i) begin
        if (rst0_i) begin
            data0_o <= '0;
        end else begin
            data0_o <= mem[addr0_i];
        end
    end

    always_ff @(posedge clk1_i or posedge rst1_i) begin
        if (rst1_i) begin
            data1_o <= '0;
        end else begin
            data1_o <= mem[addr1_i];
        end
    end

endmodule

// File: rtl/jpeg_idct_transpose.sv
// Single-buffered 8x8 transpose between the row and column IDCT passes: fill row-major,
// drain column-major (or row-major when TRANSPOSE_EN=0) through a 2-entry skid buffer.
module jpeg_idct_transpose
    import jpeg_idct_pkg::*;
#(
    parameter bit TRANSPOSE_EN = 1'b1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                inport_valid_i,
    input  logic [SAMPLE_W-1:0] inport_data_i,
    output logic                inport_accept_o,
    output logic                outport_valid_o,
    output logic [SAMPLE_W-1:0] outport_data_o,
    output logic                outport_last_o,
    input  logic                outport_accept_i
);

    xpose_state_t state_q, state_d;

    logic [5:0]          wr_idx_q;
    logic [SAMPLE_W-1:0] hold_q;
    logic [6:0]          rd_cnt_q;
    logic                inflight_q;
    logic                rd_half_q;
    logic                rd_last_q;

    logic [1:0][SAMPLE_W-1:0] skid_data_q;
    logic [1:0]               skid_last_q;
    logic                     skid_wr_ptr_q;
    logic                     skid_rd_ptr_q;
    logic [1:0]               skid_cnt_q;

    logic                in_fire;
    logic                ram_wr;
    logic [WORD_W-1:0]   ram_rd_data;
    logic [WORD_W-1:0]   unused_rd0;
    logic [5:0]          rd_j;
    logic [2:0]          rd_row;
    logic [2:0]          rd_col;
    elem_loc_t           rd_loc;
    logic [SAMPLE_W-1:0] ram_half_data;
    logic                skid_empty;
    logic                out_valid;
    logic [SAMPLE_W-1:0] head_data;
    logic                head_last;
    logic                out_fire;
    logic                drain_done;
    logic                skid_push;
    logic                skid_pop;
    logic [2:0]          occupancy;
    logic                rd_issue;

    assign inport_accept_o = (state_q == ST_FILL);
    assign in_fire         = inport_valid_i && inport_accept_o;
    assign ram_wr          = in_fire && wr_idx_q[0];

    assign rd_j   = rd_cnt_q[5:0];
    assign rd_row = TRANSPOSE_EN ? rd_j[2:0] : rd_j[5:3];
    assign rd_col = TRANSPOSE_EN ? rd_j[5:3] : rd_j[2:0];
    assign rd_loc = elem_loc(rd_row, rd_col);

    assign ram_half_data = rd_half_q ? ram_rd_data[WORD_W-1:SAMPLE_W]
                                     : ram_rd_data[SAMPLE_W-1:0];

    // With the skid buffer empty the RAM output is presented directly.
    assign skid_empty = (skid_cnt_q == 2'd0);
    assign out_valid  = !skid_empty || inflight_q;
    assign head_data  = skid_empty ? ram_half_data : skid_data_q[skid_rd_ptr_q];
    assign head_last  = skid_empty ? rd_last_q : skid_last_q[skid_rd_ptr_q];
    assign out_fire   = out_valid && outport_accept_i;
    assign drain_done = out_fire && head_last;

    assign skid_pop  = out_fire && !skid_empty;
    assign skid_push = inflight_q && !(skid_empty && out_fire);

    // Credit: buffered + in-flight, less whatever leaves this cycle, must stay below 2.
    assign occupancy = {1'b0, skid_cnt_q} + {2'b0, inflight_q} - {2'b0, out_fire};
    assign rd_issue  = (state_q == ST_DRAIN) && !rd_cnt_q[6] && (occupancy < 3'd2);

    assign outport_valid_o = out_valid;
    assign outport_data_o  = out_valid ? head_data : '0;
    assign outport_last_o  = out_valid && head_last;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_FILL: begin
                if (in_fire && (wr_idx_q == 6'd63)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_done) begin
                    state_d = ST_FILL;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= ST_FILL;
            wr_idx_q      <= '0;
            hold_q        <= '0;
            rd_cnt_q      <= '0;
            inflight_q    <= 1'b0;
            rd_half_q     <= 1'b0;
            rd_last_q     <= 1'b0;
            skid_data_q   <= '0;
            skid_last_q   <= '0;
            skid_wr_ptr_q <= 1'b0;
            skid_rd_ptr_q <= 1'b0;
            skid_cnt_q    <= '0;
        end else begin
            state_q <= state_d;

            if (in_fire) begin
                wr_idx_q <= wr_idx_q + 6'd1;
                if (!wr_idx_q[0]) begin
                    hold_q <= inport_data_i;
                end
            end

            if (drain_done) begin
                rd_cnt_q <= '0;
            end else if (rd_issue) begin
                rd_cnt_q <= rd_cnt_q + 7'd1;
            end

            inflight_q <= rd_issue;
            if (rd_issue) begin
                rd_half_q <= rd_loc.half;
                rd_last_q <= &rd_j;
            end

            if (skid_push) begin
                skid_data_q[skid_wr_ptr_q] <= ram_half_data;
                skid_last_q[skid_wr_ptr_q] <= rd_last_q;
                skid_wr_ptr_q              <= !skid_wr_ptr_q;
            end
            if (skid_pop) begin
                skid_rd_ptr_q <= !skid_rd_ptr_q;
            end
            skid_cnt_q <= skid_cnt_q + {1'b0, skid_push} - {1'b0, skid_pop};
        end
    end

    jpeg_idct_transpose_ram u_ram (
        .clk0_i  (clk_i),
        .rst0_i  (rst_i),
        .addr0_i (wr_idx_q[5:1]),
        .data0_i ({inport_data_i, hold_q}),
        .wr0_i   (ram_wr),
        .clk1_i  (clk_i),
        .rst1_i  (rst_i),
        .addr1_i (rd_loc.addr),
        .data1_i ('0),
        .wr1_i   (1'b0),
        .data0_o (unused_rd0),
        .data1_o (ram_rd_data)
    );

endmodule
